// File: rtl/hrm_dump_streamer.sv
// Host-side dump reader: walks the CPU dump port and emits a framed
// byte stream (A5, tagged sections, 5A) over a valid/ready handshake.
module hrm_dump_streamer #(
  parameter logic [7:0] START_BYTE = 8'hA5,
  parameter logic [7:0] END_BYTE   = 8'h5A,
  parameter int         FIFO_DEPTH = 32,
  parameter int         POS_W      = 5
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic [2:0]       o_dmp_chip_select,
  output logic [POS_W-1:0] o_dmp_fifo_pos,
  input  logic [7:0]       i_dmp_data,
  input  logic             i_dmp_valid,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_valid,
  input  logic             i_tx_ready
);

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    HDR,
    TAG,
    DATA,
    TRAIL
  } state_t;

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(FIFO_DEPTH - 1);

  state_t     state;
  logic [2:0] sec;
  logic [5:0] cnt;
  logic [5:0] cnt_in;
  logic [5:0] cnt_out;
  logic [5:0] idx;
  logic [5:0] cur_len;
  logic       fire;

  function automatic logic [2:0] tag_of(input logic [2:0] s);
    logic [2:0] t;
    unique case (s)
      3'd0:    t = 3'd0;
      3'd1:    t = 3'd1;
      3'd2:    t = 3'd2;
      3'd3:    t = 3'd4;
      default: t = 3'd5;
    endcase
    return t;
  endfunction

  assign fire = o_tx_valid && i_tx_ready;

  always_comb begin
    cur_len = 6'd1;
    if (sec == 3'd0) cur_len = cnt_in;
    else if (sec == 3'd1) cur_len = cnt_out;
  end

  // Both FIFO lengths are counted before the header goes out, so the
  // stream itself never stalls once the first byte is presented.
  // The next select/pos is set when a byte is loaded, so it is stable
  // for at least one full cycle before the following capture.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state             <= IDLE;
      o_busy            <= 1'b0;
      o_done            <= 1'b0;
      o_tx_valid        <= 1'b0;
      o_tx_data         <= 8'h00;
      o_dmp_chip_select <= 3'd0;
      o_dmp_fifo_pos    <= '0;
      sec               <= 3'd0;
      cnt               <= 6'd0;
      cnt_in            <= 6'd0;
      cnt_out           <= 6'd0;
      idx               <= 6'd0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_start) begin
            o_busy            <= 1'b1;
            sec               <= 3'd0;
            cnt               <= 6'd0;
            o_dmp_chip_select <= 3'd0;
            o_dmp_fifo_pos    <= '0;
            state             <= COUNT;
          end
        end
        COUNT: begin
          if (i_dmp_valid && o_dmp_fifo_pos != LAST_POS) begin
            cnt            <= cnt + 6'd1;
            o_dmp_fifo_pos <= o_dmp_fifo_pos + 1'b1;
          end else if (sec == 3'd0) begin
            cnt_in            <= cnt + 6'(i_dmp_valid);
            cnt               <= 6'd0;
            sec               <= 3'd1;
            o_dmp_chip_select <= 3'd1;
            o_dmp_fifo_pos    <= '0;
          end else begin
            cnt_out           <= cnt + 6'(i_dmp_valid);
            sec               <= 3'd0;
            o_dmp_chip_select <= 3'd0;
            o_dmp_fifo_pos    <= '0;
            o_tx_data         <= START_BYTE;
            o_tx_valid        <= 1'b1;
            state             <= HDR;
          end
        end
        HDR: begin
          if (fire) begin
            o_tx_data         <= {5'd0, tag_of(sec)};
            o_dmp_chip_select <= tag_of(sec);
            o_dmp_fifo_pos    <= '0;
            state             <= TAG;
          end
        end
        TAG: begin
          if (fire) begin
            o_tx_data <= {2'b00, cur_len};
            idx       <= 6'd0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (fire) begin
            if (idx != cur_len) begin
              o_tx_data      <= i_dmp_data;
              o_dmp_fifo_pos <= POS_W'(idx + 6'd1);
              idx            <= idx + 6'd1;
            end else if (sec == 3'd4) begin
              o_tx_data         <= END_BYTE;
              o_dmp_chip_select <= 3'd0;
              o_dmp_fifo_pos    <= '0;
              state             <= TRAIL;
            end else begin
              sec               <= sec + 3'd1;
              o_tx_data         <= {5'd0, tag_of(sec + 3'd1)};
              o_dmp_chip_select <= tag_of(sec + 3'd1);
              o_dmp_fifo_pos    <= '0;
              state             <= TAG;
            end
          end
        end
        TRAIL: begin
          if (fire) begin
            o_tx_valid <= 1'b0;
            o_tx_data  <= 8'h00;
            o_busy     <= 1'b0;
            o_done     <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hrm_dump_streamer.sv
// Scoreboard bench for hrm_dump_streamer with a behavioural
// model of the CPU dump mux.
module tb_hrm_dump_streamer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done;
  logic [2:0] cs;
  logic [4:0] pos;
  logic [7:0] dmp_data;
  logic       dmp_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;

  logic [7:0] inbox  [32];
  logic [7:0] outbox [32];
  int         n_in = 0;
  int         n_out = 0;
  logic [7:0] pc = 8'h00;
  logic [7:0] rr = 8'h00;
  logic [7:0] ir = 8'h00;
  int         mode = 0;

  logic [7:0] exp_q [$];
  int         tests = 0;
  int         fails = 0;
  int         done_cnt = 0;
  int         frame_bytes = 0;

  hrm_dump_streamer dut (
    .clk               (clk),
    .i_rst_n           (rst_n),
    .i_start           (start),
    .o_busy            (busy),
    .o_done            (done),
    .o_dmp_chip_select (cs),
    .o_dmp_fifo_pos    (pos),
    .i_dmp_data        (dmp_data),
    .i_dmp_valid       (dmp_valid),
    .o_tx_data         (tx_data),
    .o_tx_valid        (tx_valid),
    .i_tx_ready        (tx_ready)
  );

  always #5 clk = ~clk;

  always_comb begin
    dmp_data  = 8'h00;
    dmp_valid = 1'b1;
    case (cs)
      3'd0: begin
        dmp_valid = (int'(pos) < n_in);
        if (dmp_valid) dmp_data = inbox[pos];
      end
      3'd1: begin
        dmp_valid = (int'(pos) < n_out);
        if (dmp_valid) dmp_data = outbox[pos];
      end
      3'd2: dmp_data = pc;
      3'd4: dmp_data = rr;
      3'd5: dmp_data = ir;
      default: dmp_data = 8'h00;
    endcase
  end

  always @(posedge clk) begin
    #1;
    tx_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
  end

  function automatic void chk(input string name,
                              input logic [31:0] act,
                              input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endfunction

  task automatic monitor();
    logic       pv, pr;
    logic [7:0] pd;
    pv = 1'b0; pr = 1'b0; pd = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
        continue;
      end
      if (pv && !pr) begin
        chk("hold_valid", 32'(tx_valid), 32'd1);
        chk("hold_data", 32'(tx_data), 32'(pd));
      end
      if (tx_valid && tx_ready) begin
        frame_bytes++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_byte: got %0h expected none", tx_data);
        end else begin
          chk("stream_byte", 32'(tx_data), 32'(exp_q.pop_front()));
        end
      end
      if (done) done_cnt++;
      pv = tx_valid; pr = tx_ready; pd = tx_data;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    chk({tag, "_cs"}, 32'(cs), 32'd0);
    chk({tag, "_pos"}, 32'(pos), 32'd0);
  endtask

  task automatic push_frame();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'(n_in));
    for (int i = 0; i < n_in; i++) exp_q.push_back(inbox[i]);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'(n_out));
    for (int i = 0; i < n_out; i++) exp_q.push_back(outbox[i]);
    exp_q.push_back(8'h02); exp_q.push_back(8'h01); exp_q.push_back(pc);
    exp_q.push_back(8'h04); exp_q.push_back(8'h01); exp_q.push_back(rr);
    exp_q.push_back(8'h05); exp_q.push_back(8'h01); exp_q.push_back(ir);
    exp_q.push_back(8'h5A);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic run_frame(input int nbytes, input bit extra);
    int  d0;
    bit  seen;
    d0 = done_cnt;
    frame_bytes = 0;
    seen = 1'b0;
    pulse_start();
    for (int i = 0; i < 3000; i++) begin
      start = extra && (i == 5 || i == 12);
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chk("done_seen", 32'(seen), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    repeat (40) @(negedge clk);
    chk("done_count", 32'(done_cnt), 32'(d0 + 1));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("frame_bytes", 32'(frame_bytes), 32'(nbytes));
    exp_q.delete();
  endtask

  task automatic load_case2();
    n_in = 3; inbox[0] = 8'h07; inbox[1] = 8'hF9; inbox[2] = 8'h2C;
    n_out = 1; outbox[0] = 8'h01;
    pc = 8'h12; rr = 8'h80; ir = 8'h03;
  endtask

  task automatic load_case3();
    n_in = 32;
    for (int i = 0; i < 32; i++) inbox[i] = 8'(i);
    n_out = 0;
    pc = 8'h12; rr = 8'h80; ir = 8'h03;
  endtask

  initial begin
    logic [7:0] c1 [15];
    bit         hit;
    c1 = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h00, 8'h02, 8'h01, 8'h12,
           8'h04, 8'h01, 8'h80, 8'h05, 8'h01, 8'h03, 8'h5A};
    for (int i = 0; i < 32; i++) begin
      inbox[i] = 8'h00;
      outbox[i] = 8'h00;
    end
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    n_in = 0; n_out = 0; pc = 8'h12; rr = 8'h80; ir = 8'h03;
    for (int i = 0; i < 15; i++) exp_q.push_back(c1[i]);
    run_frame(15, 1'b0);

    load_case2();
    push_frame();
    run_frame(19, 1'b0);

    load_case3();
    push_frame();
    run_frame(47, 1'b0);

    mode = 1;
    load_case2();
    push_frame();
    run_frame(19, 1'b0);
    mode = 0;

    load_case3();
    push_frame();
    frame_bytes = 0;
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (frame_bytes >= 10) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reached_mid_data", 32'(hit), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_in = 0; n_out = 0; pc = 8'h12; rr = 8'h80; ir = 8'h03;
    for (int i = 0; i < 15; i++) exp_q.push_back(c1[i]);
    run_frame(15, 1'b0);

    load_case2();
    push_frame();
    run_frame(19, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
